// File: rtl/mandala_anim_ctrl.sv
// Frame-rate animation controller for the mandala generator: vsync framing, speed divider,
// pause / reverse / debounced single-step. Optional build macro ANIM_PINGPONG_EN bounces the pattern.
module mandala_anim_ctrl #(
    parameter int unsigned PAT_W           = 10,
    parameter int unsigned COL_W           = 8,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic [2:0]       speed,
    input  logic             pause,
    input  logic             reverse,
    input  logic             step_btn,
    output logic [PAT_W-1:0] pattern_counter,
    output logic [COL_W-1:0] color_counter,
    output logic             frame_tick,
    output logic             advance,
    output logic             paused
);

    localparam int unsigned SPD_W = 3;
    localparam int unsigned DBC_W = 4;
    localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_PAUSED    = 2'd1,
        ST_STEP_PEND = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_vsync_q;
    logic [SPD_W-1:0]   r_div_cnt;
    logic               r_step_s1;
    logic               r_step_s2;
    logic               r_step_prev;
    logic [DBC_W-1:0]   r_dbc_cnt;
    logic               r_step_acc;
    logic               r_step_evt;
    logic               r_frame_tick;
    logic               r_advance;
    logic               r_paused;
    logic [PAT_W-1:0]   r_pattern;
    logic [COL_W-1:0]   r_color;
    logic               w_edge;
    logic               w_go;
    logic               w_adv;
    logic [DBC_W-1:0]   w_dbc_nxt;
    logic               w_accept;
    logic [PAT_W-1:0]   w_pat_nxt;

    assign w_edge = vsync & ~r_vsync_q;
    assign w_go   = (r_div_cnt >= speed);

    // Consecutive-equal count of the synchronised button, sampled once per frame
    always_comb begin
        w_dbc_nxt = DBC_W'(1);
        if (r_step_s2 == r_step_prev) begin
            w_dbc_nxt = (r_dbc_cnt >= DBC_MAX) ? r_dbc_cnt : r_dbc_cnt + DBC_W'(1);
        end
    end
    assign w_accept = (w_dbc_nxt == DBC_MAX);

    // Input synchroniser, vsync edge detect, divider and debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_q   <= 1'b0;
            r_div_cnt   <= '0;
            r_step_s1   <= 1'b0;
            r_step_s2   <= 1'b0;
            r_step_prev <= 1'b0;
            r_dbc_cnt   <= '0;
            r_step_acc  <= 1'b0;
            r_step_evt  <= 1'b0;
        end else begin
            r_vsync_q  <= vsync;
            r_step_s1  <= step_btn;
            r_step_s2  <= r_step_s1;
            r_step_evt <= 1'b0;
            if (w_edge) begin
                r_div_cnt   <= w_go ? '0 : r_div_cnt + SPD_W'(1);
                r_step_prev <= r_step_s2;
                r_dbc_cnt   <= w_dbc_nxt;
                if (w_accept) begin
                    r_step_acc <= r_step_s2;
                end
                r_step_evt  <= w_accept & r_step_s2 & ~r_step_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PAUSED yields to a released pause before honouring a step request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (pause) w_state_nxt = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (!pause)          w_state_nxt = ST_RUN;
                else if (r_step_evt) w_state_nxt = ST_STEP_PEND;
            end
            ST_STEP_PEND: begin
                if (w_edge) w_state_nxt = pause ? ST_PAUSED : ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_adv = 1'b0;
        case (r_state)
            ST_RUN:       w_adv = w_edge & w_go & ~pause;
            ST_STEP_PEND: w_adv = w_edge;
            default:      w_adv = 1'b0;
        endcase
    end

`ifdef ANIM_PINGPONG_EN
    logic r_dir_up;
    logic w_dir_up_nxt;

    // Hold the end value for one advance while the direction turns around
    always_comb begin
        w_pat_nxt    = r_pattern;
        w_dir_up_nxt = r_dir_up;
        if (r_dir_up) begin
            if (r_pattern == {PAT_W{1'b1}}) w_dir_up_nxt = 1'b0;
            else                            w_pat_nxt    = r_pattern + PAT_W'(1);
        end else begin
            if (r_pattern == '0) w_dir_up_nxt = 1'b1;
            else                 w_pat_nxt    = r_pattern - PAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_up <= 1'b1;
        end else if (w_adv) begin
            r_dir_up <= w_dir_up_nxt;
        end
    end
`else
    assign w_pat_nxt = reverse ? r_pattern - PAT_W'(1) : r_pattern + PAT_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
            r_advance    <= 1'b0;
            r_paused     <= 1'b0;
            r_pattern    <= '0;
            r_color      <= '0;
        end else begin
            r_frame_tick <= w_edge;
            r_advance    <= w_adv;
            r_paused     <= (w_state_nxt != ST_RUN);
            if (w_adv) begin
                r_pattern <= w_pat_nxt;
`ifdef ANIM_PINGPONG_EN
                r_color   <= r_color + COL_W'(1);
`else
                r_color   <= reverse ? r_color - COL_W'(1) : r_color + COL_W'(1);
`endif
            end
        end
    end

    assign pattern_counter = r_pattern;
    assign color_counter   = r_color;
    assign frame_tick      = r_frame_tick;
    assign advance         = r_advance;
    assign paused          = r_paused;

endmodule

// File: tb/tb_mandala_anim_ctrl.sv
// Bench for mandala_anim_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_mandala_anim_ctrl;

    localparam int unsigned PAT_W = 10;
    localparam int unsigned COL_W = 8;
    localparam int unsigned DEB   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             vsync = 1'b0;
    logic [2:0]       speed = 3'd0;
    logic             pause = 1'b0;
    logic             reverse = 1'b0;
    logic             step_btn = 1'b0;
    logic [PAT_W-1:0] pattern_counter;
    logic [COL_W-1:0] color_counter;
    logic             frame_tick;
    logic             advance;
    logic             paused;

    mandala_anim_ctrl #(.PAT_W(PAT_W), .COL_W(COL_W), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .speed(speed), .pause(pause),
        .reverse(reverse), .step_btn(step_btn), .pattern_counter(pattern_counter),
        .color_counter(color_counter), .frame_tick(frame_tick), .advance(advance),
        .paused(paused)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Frame-level reference model
    logic [PAT_W-1:0] m_pat;
    logic [COL_W-1:0] m_col;
    int               m_frames_waited;
    bit               m_hold;
    bit               m_step_due;
    bit               m_up;
    bit               m_acc;
    bit               m_evt;
    bit               m_adv;
    bit               hist[$];
    logic             last_adv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = '0; m_col = '0; m_frames_waited = 0;
        m_hold = 1'b0; m_step_due = 1'b0; m_up = 1'b1; m_acc = 1'b0; m_evt = 1'b0;
        hist.delete();
    endtask

    task automatic model_frame();
        bit go;
        bit all_eq;
        if (!m_step_due) m_hold = pause;
        go = (m_frames_waited >= int'(speed));
        m_frames_waited = go ? 0 : m_frames_waited + 1;
        m_adv = m_step_due || (!m_hold && go);
        if (m_step_due) begin
            m_step_due = 1'b0;
            m_hold = pause;
        end
        if (m_adv) begin
`ifdef ANIM_PINGPONG_EN
            if (m_up) begin
                if (m_pat == {PAT_W{1'b1}}) m_up = 1'b0; else m_pat = m_pat + 1'b1;
            end else begin
                if (m_pat == '0) m_up = 1'b1; else m_pat = m_pat - 1'b1;
            end
            m_col = m_col + 1'b1;
`else
            m_pat = reverse ? m_pat - 1'b1 : m_pat + 1'b1;
            m_col = reverse ? m_col - 1'b1 : m_col + 1'b1;
`endif
        end
        hist.push_back(step_btn);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_evt = 1'b0;
        if (hist.size() == DEB) begin
            all_eq = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
            if (all_eq) begin
                m_evt = hist[0] && !m_acc;
                m_acc = hist[0];
            end
        end
    endtask

    task automatic do_frame();
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        model_frame();
        last_adv = advance;
        chk("frame_tick_hi", 32'(frame_tick), 32'd1);
        chk("advance", 32'(advance), 32'(m_adv));
        chk("pattern", 32'(pattern_counter), 32'(m_pat));
        chk("color", 32'(color_counter), 32'(m_col));
        chk("paused", 32'(paused), 32'(m_hold || m_step_due));
        @(negedge clk);
        chk("frame_tick_lo", 32'(frame_tick), 32'd0);
        chk("advance_lo", 32'(advance), 32'd0);
        vsync = 1'b0;
        if (m_evt && m_hold && !m_step_due) m_step_due = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        last_adv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pattern", 32'(pattern_counter), 32'd0);
        chk("rst_color", 32'(color_counter), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        rst_n = 1'b1;

        repeat (3) do_frame();
`ifndef ANIM_PINGPONG_EN
        chk("three_frames_pat", 32'(pattern_counter), 32'd3);
        chk("three_frames_col", 32'(color_counter), 32'd3);
`endif
        speed = 3'd3;
        repeat (8) do_frame();
        repeat (2) do_frame();
        speed = 3'd0;
        do_frame();
        chk("speed_drop_adv", 32'(last_adv), 32'd1);
        reverse = 1'b1;
        do_frame();
        reverse = 1'b0;
`ifndef ANIM_PINGPONG_EN
        chk("pre_pause_pat", 32'(pattern_counter), 32'd5);
`endif
        pause = 1'b1;
        repeat (4) do_frame();
        chk("paused_flag", 32'(paused), 32'd1);
        step_btn = 1'b1;
        repeat (3) do_frame();
        step_btn = 1'b0;
        do_frame();
        chk("step_adv", 32'(last_adv), 32'd1);
        chk("step_back_paused", 32'(paused), 32'd1);
`ifndef ANIM_PINGPONG_EN
        chk("step_pat", 32'(pattern_counter), 32'd6);
`endif
        step_btn = 1'b1;
        do_frame();
        step_btn = 1'b0;
        repeat (4) do_frame();
`ifndef ANIM_PINGPONG_EN
        chk("glitch_pat", 32'(pattern_counter), 32'd6);
`endif
        pause = 1'b0;

        do_reset();
        reverse = 1'b1;
        repeat (2) do_frame();
`ifndef ANIM_PINGPONG_EN
        chk("rev_pat", 32'(pattern_counter), 32'd1022);
        chk("rev_col", 32'(color_counter), 32'd254);
`endif
        step_btn = 1'b1;
        repeat (4) do_frame();
        step_btn = 1'b0;
        repeat (4) do_frame();
`ifndef ANIM_PINGPONG_EN
        chk("run_step_pat", 32'(pattern_counter), 32'd1014);
`endif

        reverse = 1'b0;
        pause = 1'b1;
        step_btn = 1'b1;
        repeat (3) do_frame();
        step_btn = 1'b0;
        chk("pend_paused", 32'(paused), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_pattern", 32'(pattern_counter), 32'd0);
        chk("arst_color", 32'(color_counter), 32'd0);
        chk("arst_paused", 32'(paused), 32'd0);
        chk("arst_advance", 32'(advance), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) do_frame();
        chk("no_step_after_rst", 32'(pattern_counter), 32'd0);
        pause = 1'b0;

`ifdef ANIM_PINGPONG_EN
        begin
            logic [PAT_W-1:0] exp_pat [5];
            exp_pat = '{10'd1022, 10'd1023, 10'd1023, 10'd1022, 10'd1021};
            do_reset();
            speed = 3'd0;
            repeat (1021) do_frame();
            chk("pp_preload", 32'(pattern_counter), 32'd1021);
            for (int k = 0; k < 5; k++) begin
                do_frame();
                chk("pp_pattern", 32'(pattern_counter), 32'(exp_pat[k]));
                chk("pp_color", 32'(color_counter), 32'((1021 + k + 1) % 256));
            end
        end
`endif

        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 7) == 0) speed = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) reverse = ~reverse;
            if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
            do_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
